// File: rtl/led_out_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// A write is accepted on any cycle with chipselect high and write_n low (no wait states); readdata is registered
// and returns the register addressed in the previous cycle, whether or not chipselect was asserted.
interface led_out_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_out_pio.sv
// LED output PIO: data register with set/clear aliases, plus a prescaled blink phase XORed into masked bits.
module led_out_pio #(
  parameter int                    DATA_WIDTH   = 10,
  parameter int                    PERIOD_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  led_out_pio_if.slave          avs,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   r_mask;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_counter;
  logic                    r_phase;
  logic [31:0]             r_readdata;

  logic                    w_wr;
  logic                    w_wr_period;
  logic [DATA_WIDTH-1:0]   w_wd_data;
  logic [31:0]             w_rd_mux;
  logic                    w_unused;

  assign w_wr        = avs.chipselect & ~avs.write_n;
  assign w_wr_period = w_wr && (avs.address == 3'd2);
  assign w_wd_data   = avs.writedata[DATA_WIDTH-1:0];
  assign w_unused    = ^avs.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VALUE;
      r_mask   <= '0;
      r_period <= '0;
    end else if (w_wr) begin
      case (avs.address)
        3'd0:    r_data   <= w_wd_data;
        3'd1:    r_mask   <= w_wd_data;
        3'd2:    r_period <= avs.writedata[PERIOD_WIDTH-1:0];
        3'd4:    r_data   <= r_data | w_wd_data;
        3'd5:    r_data   <= r_data & ~w_wd_data;
        default: ;
      endcase
    end
  end

  // A PERIOD write restarts the blink from phase 0, taking priority over a coincident terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_phase   <= 1'b0;
    end else if (w_wr_period || (r_period == '0)) begin
      r_counter <= '0;
      r_phase   <= 1'b0;
    end else if (r_counter == r_period) begin
      r_counter <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_counter <= r_counter + 1'b1;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (avs.address)
      3'd0:    w_rd_mux[DATA_WIDTH-1:0]   = r_data;
      3'd1:    w_rd_mux[DATA_WIDTH-1:0]   = r_mask;
      3'd2:    w_rd_mux[PERIOD_WIDTH-1:0] = r_period;
      3'd3:    w_rd_mux[1:0]              = {(r_period != '0), r_phase};
      default: w_rd_mux                   = '0;
    endcase
  end

  // Read data samples pre-write register values, giving one cycle of read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign avs.readdata = r_readdata;
  assign out_port     = r_data ^ (r_mask & {DATA_WIDTH{r_phase}});

endmodule
